// File: rtl/display_scan_decoder_if.sv
// Bus bundle for the 3-digit multiplexed 7-segment display and its decoded result.
// The master drives hex/dsel (display side or bench); the slave is the decoder.
interface display_scan_decoder_if;
  logic [6:0] hex;
  logic [2:0] dsel;
  logic [9:0] value;
  logic       valid;
  logic       frame_err;

  modport master (output hex, dsel, input value, valid, frame_err);
  modport slave  (input hex, dsel, output value, valid, frame_err);
endinterface

// File: rtl/display_scan_decoder.sv
// Recovers the binary value shown on a multiplexed 3-digit 7-segment display.
// Optional macro SCAN_DECODE_BLANK_EN: the blank pattern 7F decodes as digit 0.
module display_scan_decoder #(
  parameter int SETTLE = 4,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  display_scan_decoder_if.slave  bus
);

  localparam logic [CNT_W-1:0] SETTLE_C  = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE - 1);

  logic [6:0]       prev_hex;
  logic [2:0]       prev_dsel;
  logic [CNT_W-1:0] settle_cnt;
  logic             done_dwell;
  logic [3:0]       dig_u, dig_t, dig_h;
  logic [2:0]       seen;
  logic             err_acc;
  logic [9:0]       value_r;
  logic             valid_r, frame_err_r;

  logic [2:0]       sel;
  logic             dsel_legal, stable, sample, complete;
  logic [4:0]       dec;
  logic [9:0]       hundreds_part;
  logic [6:0]       tens_part;
  logic [9:0]       frame_value;

  // Returns {ok, digit}; ok=0 marks a pattern that is not a decimal digit.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h40:   seg_decode = 5'h10;
      7'h79:   seg_decode = 5'h11;
      7'h24:   seg_decode = 5'h12;
      7'h30:   seg_decode = 5'h13;
      7'h19:   seg_decode = 5'h14;
      7'h12:   seg_decode = 5'h15;
      7'h02:   seg_decode = 5'h16;
      7'h78:   seg_decode = 5'h17;
      7'h00:   seg_decode = 5'h18;
      7'h10:   seg_decode = 5'h19;
`ifdef SCAN_DECODE_BLANK_EN
      7'h7F:   seg_decode = 5'h10;
`else
      7'h7F:   seg_decode = 5'h00;
`endif
      default: seg_decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    sel           = ~bus.dsel;
    dsel_legal    = (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100);
    stable        = dsel_legal && (bus.hex == prev_hex) && (bus.dsel == prev_dsel);
    sample        = stable && !done_dwell && (settle_cnt >= SETTLE_M1);
    complete      = (seen == 3'b111);
    dec           = seg_decode(bus.hex);
    hundreds_part = 10'(dig_h) * 10'd100;
    tens_part     = 7'(dig_t) * 7'd10;
    frame_value   = hundreds_part + 10'(tens_part) + 10'(dig_u);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_hex  <= 7'h00;
      prev_dsel <= 3'b000;
    end else begin
      prev_hex  <= bus.hex;
      prev_dsel <= bus.dsel;
    end
  end

  // A dwell samples once, on the edge where the counter arrives at SETTLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_cnt <= '0;
      done_dwell <= 1'b0;
    end else if (!stable) begin
      settle_cnt <= '0;
      done_dwell <= 1'b0;
    end else begin
      if (settle_cnt < SETTLE_C)
        settle_cnt <= settle_cnt + 1'b1;
      if (sample)
        done_dwell <= 1'b1;
    end
  end

  // Completion clears the frame state; a sample in that same cycle opens the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dig_u       <= 4'd0;
      dig_t       <= 4'd0;
      dig_h       <= 4'd0;
      seen        <= 3'b000;
      err_acc     <= 1'b0;
      value_r     <= 10'd0;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      if (complete) begin
        if (!err_acc) begin
          value_r <= frame_value;
          valid_r <= 1'b1;
        end else begin
          frame_err_r <= 1'b1;
        end
      end
      if (sample) begin
        seen    <= (complete ? 3'b000 : seen) | sel;
        err_acc <= (complete ? 1'b0 : err_acc) | !dec[4];
        if (dec[4]) begin
          if (sel[0]) dig_u <= dec[3:0];
          if (sel[1]) dig_t <= dec[3:0];
          if (sel[2]) dig_h <= dec[3:0];
        end
      end else if (complete) begin
        seen    <= 3'b000;
        err_acc <= 1'b0;
      end
    end
  end

  assign bus.value     = value_r;
  assign bus.valid     = valid_r;
  assign bus.frame_err = frame_err_r;

endmodule

// File: doc/display_scan_decoder.md
Name: display_scan_decoder

Overview:
- Decodes the multiplexed 3-digit 7-segment display bus (hex/dsel) back into the 10-bit binary value it shows. This is the inverse of the binary-to-display mux.
- Sits beside the display outputs of the top level as an on-chip monitor/loopback checker. It can also be driven from a bench that replays display traffic.
- Samples each digit after its select has settled, then assembles a full frame and emits the value with a one-cycle valid pulse.

Parameters:
- SETTLE, 4, clk cycles that dsel and hex must hold unchanged before a digit is sampled (1..255).
- CNT_W, 8, width of the settle counter; must satisfy 2^CNT_W > SETTLE.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- hex  input  7  segment bus, active-low, bit order {g,f,e,d,c,b,a} (hex[0]=a).
- dsel  input  3  digit select, active-low one-hot: dsel[0]=units, dsel[1]=tens, dsel[2]=hundreds.
- value  output  10  last good decoded value = H*100 + T*10 + U (0..999).
- valid  output  1  one-cycle pulse when value is updated.
- frame_err  output  1  one-cycle pulse when a completed frame contained an undecodable digit.

Behaviour:
- Reset (rst=0, async):
  - value=0, valid=0, frame_err=0.
  - Digit registers = 0, seen[2:0] = 0, err_acc = 0, settle counter = 0, done_dwell = 0.
- Input registration:
  - hex and dsel are registered once (prev copies) for change detection.
  - No synchroniser is included; the inputs are same-clock-domain.
- Dwell tracking:
  - dsel is legal when exactly one bit is 0.
  - Counter clears to 0 and done_dwell clears when dsel or hex differs from its previous-cycle copy, or when dsel is illegal (111, or multi-low).
  - Otherwise the counter increments, saturating at SETTLE.
- Sample:
  - Taken on the cycle the counter reaches SETTLE with done_dwell=0; this sets done_dwell=1.
  - Each dwell therefore samples exactly once, however long it lasts.
- Segment decode (active-low patterns, hex value):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Any other pattern is illegal: the digit register keeps its old value, err_acc is set, and the seen bit is set.
- Slot write:
  - A sample writes the slot selected by dsel and sets its seen bit.
  - A repeat sample of an already-seen slot before frame completion overwrites it; last wins.
- Frame complete:
  - Occurs on the cycle after the sample that makes seen==111.
  - If err_acc==0: value <= H*100+T*10+U, using a 10-bit result with 7-bit/4-bit intermediate products, no truncation possible for digits 0..9. valid=1 for one cycle.
  - Else: value is unchanged and frame_err=1 for one cycle.
  - In both cases seen and err_acc clear in that same cycle.
  - A sample arriving in the completion cycle counts toward the next frame.
- valid and frame_err are never high together and are never high for two consecutive cycles.
- Latency: the sample is taken SETTLE+1 cycles after a stable dsel/hex change; valid follows the third digit's sample by 1 cycle.
- Reset mid-frame discards all partial digits; the first frame after reset needs all three digits again.
- Scan order is irrelevant. Any permutation of units/tens/hundreds completes a frame.

Optional Feature:
- Macro SCAN_DECODE_BLANK_EN.
- Defined: blank pattern 7F decodes as digit 0 and is not an error. This supports leading-zero blanking on the display side.
- Undefined: 7F is an illegal pattern and sets err_acc like any other undecodable pattern.

Test Plan:
- Reset, then scan units=7 (78), tens=2 (24), hundreds=1 (79), each held 10 cycles -> valid pulses once, value=127, frame_err stays 0.
- Same digits scanned hundreds->units->tens order -> value=127; valid exactly one cycle after the last sample.
- Digit held only SETTLE-1 cycles before dsel changes -> that digit is not sampled and no valid occurs until it is shown for >=SETTLE cycles.
- Tens shows 7F with units=5, hundreds=0:
  - macro off -> frame_err pulse, value keeps its prior value.
  - macro on -> valid pulse, value=5.
- dsel=100 (two low) or 111 held 20 cycles -> no sample, no pulses, counter stays 0.
- Assert rst low after two digits are sampled, release, then scan 9,9,9 -> single valid with value=999; no frame built from pre-reset digits.
